// File: rtl/tlb_op_seq.sv
// tlb_op_seq
// Sequencer for the TLB-management instructions (TLBP, TLBR, TLBWI) that
// retire from the write-back stage. It accepts one op at a time, shares TLB
// search port 1 with the data-side lookup, issues single-cycle probe, read
// and write strobes, and optionally requests a pipeline refetch.
//
// Configuration macro: TLB_OP_REFETCH_EN
//   defined     - every op ends with a one-cycle FLUSH (flush=1, flush_pc=op_pc+4)
//   not defined - no FLUSH state; flush and flush_pc stay at 0
//
// Ports:
//   clk, rst               core clock, asynchronous active-high reset
//   op_valid/op_ready      WB handshake for one TLB op
//   op_type                01=TLBP, 10=TLBR, 11=TLBWI, 00=none
//   op_pc                  PC of the TLB instruction
//   cp0_entryhi/cp0_index  CP0 EntryHi (probe key) and Index (read/write slot)
//   ds_vpn2/ds_odd/ds_asid data-side search key
//   ds_lock                data side holds port 1 for an in-flight lookup
//   ds_grant               data side owns search port 1 this cycle
//   s1_vpn2/s1_odd/s1_asid search port 1 key to the TLB
//   tlbp_pulse/tlbr_pulse  CP0 capture strobes for probe/read results
//   tlbwi_we/tlb_index     TLB write enable and read/write index
//   flush/flush_pc         refetch request and target
//   busy                   an op is in progress
module tlb_op_seq #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_type,
  input  logic [31:0]     op_pc,
  input  logic [31:0]     cp0_entryhi,
  input  logic [31:0]     cp0_index,
  input  logic [18:0]     ds_vpn2,
  input  logic            ds_odd,
  input  logic [7:0]      ds_asid,
  input  logic            ds_lock,
  output logic            ds_grant,
  output logic [18:0]     s1_vpn2,
  output logic            s1_odd,
  output logic [7:0]      s1_asid,
  output logic            tlbp_pulse,
  output logic            tlbr_pulse,
  output logic            tlbwi_we,
  output logic [IDXW-1:0] tlb_index,
  output logic            flush,
  output logic [31:0]     flush_pc,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    PROBE = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    FLUSH = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;

  // An op is taken only from IDLE; op_type 00 is swallowed without effect.
  assign accept = (state == IDLE) && op_valid && (op_type != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef TLB_OP_REFETCH_EN
  logic [31:0] op_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_pc_q <= 32'd0;
    end else if (accept) begin
      op_pc_q <= op_pc;
    end
  end

  // Bits that carry no meaning for this block are folded into one sink.
  logic unused_bits;
  assign unused_bits = ^{cp0_entryhi[12:8], cp0_index[31:IDXW], 32'(TLBNUM)};
`else
  logic unused_bits;
  assign unused_bits = ^{cp0_entryhi[12:8], cp0_index[31:IDXW], op_pc, 32'(TLBNUM)};
`endif

  // Next-state and all strobes. The strobe state is left after a single
  // cycle, which keeps the three strobes one-hot and one cycle long.
  always_comb begin
    state_next = state;
    tlbp_pulse = 1'b0;
    tlbr_pulse = 1'b0;
    tlbwi_we   = 1'b0;
    tlb_index  = '0;
    flush      = 1'b0;
    flush_pc   = 32'd0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (op_type)
            2'b01:   state_next = ds_lock ? WAIT : PROBE;
            2'b10:   state_next = READ;
            default: state_next = WRITE;
          endcase
        end
      end
      WAIT: begin
        if (!ds_lock) begin
          state_next = PROBE;
        end
      end
      PROBE: begin
        tlbp_pulse = 1'b1;
`ifdef TLB_OP_REFETCH_EN
        state_next = FLUSH;
`else
        state_next = IDLE;
`endif
      end
      READ: begin
        tlbr_pulse = 1'b1;
        tlb_index  = cp0_index[IDXW-1:0];
`ifdef TLB_OP_REFETCH_EN
        state_next = FLUSH;
`else
        state_next = IDLE;
`endif
      end
      WRITE: begin
        tlbwi_we   = 1'b1;
        tlb_index  = cp0_index[IDXW-1:0];
`ifdef TLB_OP_REFETCH_EN
        state_next = FLUSH;
`else
        state_next = IDLE;
`endif
      end
      FLUSH: begin
`ifdef TLB_OP_REFETCH_EN
        flush      = 1'b1;
        flush_pc   = op_pc_q + 32'd4;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign op_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Port 1 belongs to the data side except during the single probe cycle,
  // when it carries the EntryHi key (even page only).
  assign ds_grant = (state != PROBE);
  assign s1_vpn2  = ds_grant ? ds_vpn2 : cp0_entryhi[31:13];
  assign s1_asid  = ds_grant ? ds_asid : cp0_entryhi[7:0];
  assign s1_odd   = ds_grant ? ds_odd  : 1'b0;

endmodule
